osc_scheduler: RTL and testbench
================================

Name: osc_scheduler

Overview:
- Time-multiplexes one saturating rotation oscillator datapath across CHANNELS independent sine/cosine tone generators.
- Each channel keeps its own x/y state, shift (frequency) and enable.
- A round-robin scheduler services one enabled channel per clock.
- A valid/ready config port lets the host start, stop and retune channels; per-channel results stream out tagged with the channel number.

Parameters:
- BITS, 20, sample width (signed); MAX = 2^(BITS-1)-1
- CHANNELS, 4, number of oscillator channels (power of two, 2..16); CW = log2(CHANNELS)
- DEF_SHIFT, 5, shift loaded into every channel at reset
- Derived: MAX_SHIFT = (BITS-2)/2 (9 at BITS=20)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_chan  in  CW  target channel
- cfg_shift  in  4  new shift value
- cfg_enable  in  1  1=run channel, 0=freeze channel
- out_valid  out  1  one-cycle strobe, new sample
- out_chan  out  CW  channel of the sample
- out_sin  out  BITS  signed x of the sample
- out_cos  out  BITS  signed y of the sample

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All channels are disabled with shift=DEF_SHIFT, x=MAX, y=0.
  - ptr=0, out_valid=0, out_chan=0, out_sin=0, out_cos=0.
  - cfg_ready=0 during reset and the first cycle after it.
- Scheduler:
  - Each cycle it picks the first enabled channel found searching ptr, ptr+1, … modulo CHANNELS.
  - ptr <= picked+1 (mod CHANNELS).
  - No channel enabled: idle, ptr held, out_valid=0 next cycle.
  - Selection uses the enable values registered before any same-cycle config write.
- Datapath for picked channel c, shift s, in BITS+1 signed arithmetic:
  - nx = x + (y>>>s) - (x>>>(2s+1))
  - ny = y - (x>>>s) - (y>>>(2s+1))
- Saturation, checked in this priority order:
  - nx>MAX → (MAX,0)
  - ny>MAX → (0,MAX)
  - nx<-MAX → (-MAX,0)
  - ny<-MAX → (0,-MAX)
  - otherwise (nx,ny)
- Result handling:
  - Result written back to channel c.
  - Next cycle: out_valid=1, out_chan=c, out_sin=new x, out_cos=new y. Latency 1.
  - out_sin/out_cos hold their value when out_valid=0.
- Config handshake:
  - A write is accepted when cfg_valid&cfg_ready.
  - cfg_ready is registered; it drops for the one cycle after each accept, so the port takes at most one write per 2 cycles.
  - cfg_shift is clamped: 0→1, >MAX_SHIFT→MAX_SHIFT.
- Enable transitions on write:
  - enable 0→1: reload x=MAX, y=0.
  - 1→1: update shift only, phase kept.
  - →0: freeze state, no further samples.
- Collision: a write accepted to the channel being serviced in the same cycle wins.
  - The rotation result is discarded.
  - No out_valid for that slot.
  - ptr still advances.
- Reset mid-operation: all state returns to reset values in the same edge; no out_valid the following cycle.

Optional Feature:
- Macro: OSC_SCHED_WRAP_CNT_EN.
- When defined:
  - Adds output out_wrap (1) and a 16-bit per-channel cycle counter, exposed as output out_count (16) alongside each sample.
  - out_wrap=1 with a sample when that channel's x moves from negative to >=0.
  - The counter increments on wrap, wraps 0xFFFF→0, and clears on reset and on enable 0→1.
- When not defined: neither port nor counters exist.

Test Plan:
- Reset, write ch0 enable=1 shift=5 → first sample out_chan=0, out_sin=524032, out_cos=-16383; repeats every cycle on ch0 alone.
- Enable all 4 channels shift=5 → out_chan sequence 0,1,2,3,0,… with out_valid continuously 1. Enable only ch1,ch3 → sequence 1,3,1,3.
- Back-to-back cfg_valid held high → cfg_ready alternates 1,0,1,0; writes accepted every other cycle only.
- cfg_shift=0 and cfg_shift=15 → channel behaves as shift 1 and 9; with shift 1 from reset state → saturation case produces a clamped value, never wraps past ±524287.
- Write enable=1 to ch0 in the cycle ch0 is serviced → no out_valid next cycle; next ch0 sample equals the shift-updated step from the unrotated state.
- Disable ch2 mid-run, re-enable → ch2 restarts at first sample 524032/-16383; with OSC_SCHED_WRAP_CNT_EN, run ch0 shift=5 until x crosses 0 upward → out_wrap pulse, out_count=1.

Source files
------------

// File: rtl/osc_scheduler.sv
// osc_scheduler: one saturating rotation oscillator datapath time-shared across CHANNELS
// sine/cosine tone generators, serviced round-robin, with a valid/ready config port.
// Optional build macro OSC_SCHED_WRAP_CNT_EN adds out_wrap and a per-channel 16-bit
// wrap counter exposed as out_count.
module osc_scheduler #(
    parameter int unsigned BITS      = 20,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DEF_SHIFT = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
    input  logic [3:0]                  cfg_shift,
    input  logic                        cfg_enable,
    output logic                        out_valid,
    output logic [$clog2(CHANNELS)-1:0] out_chan,
    output logic signed [BITS-1:0]      out_sin,
    output logic signed [BITS-1:0]      out_cos
`ifdef OSC_SCHED_WRAP_CNT_EN
    ,
    output logic                        out_wrap,
    output logic [15:0]                 out_count
`endif
);

    localparam int unsigned CW        = $clog2(CHANNELS);
    localparam int unsigned MAX_SHIFT = (BITS - 2) / 2;
    localparam logic signed [BITS-1:0] MAX      = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] NEG_MAX  = -MAX;
    localparam logic signed [BITS:0]   MAX_W    = {2'b00, {(BITS-1){1'b1}}};
    localparam logic signed [BITS:0]   NEG_MAX_W = -MAX_W;

    logic signed [BITS-1:0] x_q [CHANNELS];
    logic signed [BITS-1:0] x_d [CHANNELS];
    logic signed [BITS-1:0] y_q [CHANNELS];
    logic signed [BITS-1:0] y_d [CHANNELS];
    logic [3:0]             shift_q [CHANNELS];
    logic [3:0]             shift_d [CHANNELS];
    logic [CHANNELS-1:0]    en_q, en_d;
    logic [CW-1:0]          ptr_q, ptr_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [CW-1:0]          out_chan_q, out_chan_d;
    logic signed [BITS-1:0] out_sin_q, out_sin_d;
    logic signed [BITS-1:0] out_cos_q, out_cos_d;
`ifdef OSC_SCHED_WRAP_CNT_EN
    logic [15:0]            cnt_q [CHANNELS];
    logic [15:0]            cnt_d [CHANNELS];
    logic                   out_wrap_q, out_wrap_d;
    logic [15:0]            out_count_q, out_count_d;
`endif

    logic                   found;
    logic [CW-1:0]          pick;
    logic [CW-1:0]          idx;
    logic [3:0]             s;
    logic [4:0]             s2;
    logic signed [BITS:0]   xw, yw, nx, ny;
    logic signed [BITS-1:0] rx, ry;
    logic [3:0]             shift_cl;
    logic                   accept;
    logic                   collide;

    // Round-robin pick: first enabled channel at or after ptr, using pre-write enables.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = ptr_q + CW'(i);
            if (!found && en_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // One rotation step of the picked channel in BITS+1 bits, then saturate in priority order.
    always_comb begin
        s  = shift_q[pick];
        s2 = {s, 1'b1};
        xw = {x_q[pick][BITS-1], x_q[pick]};
        yw = {y_q[pick][BITS-1], y_q[pick]};
        nx = xw + (yw >>> s) - (xw >>> s2);
        ny = yw - (xw >>> s) - (yw >>> s2);
        if (nx > MAX_W) begin
            rx = MAX;
            ry = '0;
        end else if (ny > MAX_W) begin
            rx = '0;
            ry = MAX;
        end else if (nx < NEG_MAX_W) begin
            rx = NEG_MAX;
            ry = '0;
        end else if (ny < NEG_MAX_W) begin
            rx = '0;
            ry = NEG_MAX;
        end else begin
            rx = nx[BITS-1:0];
            ry = ny[BITS-1:0];
        end
    end

    // Next state: write back the step, emit the sample, then apply any accepted config write.
    always_comb begin
        accept  = cfg_valid & cfg_ready_q;
        collide = accept && (cfg_chan == pick);
        if (cfg_shift == 4'd0) begin
            shift_cl = 4'd1;
        end else if (cfg_shift > 4'(MAX_SHIFT)) begin
            shift_cl = 4'(MAX_SHIFT);
        end else begin
            shift_cl = cfg_shift;
        end

        x_d         = x_q;
        y_d         = y_q;
        shift_d     = shift_q;
        en_d        = en_q;
        ptr_d       = ptr_q;
        out_valid_d = 1'b0;
        out_chan_d  = out_chan_q;
        out_sin_d   = out_sin_q;
        out_cos_d   = out_cos_q;
        cfg_ready_d = ~accept;
`ifdef OSC_SCHED_WRAP_CNT_EN
        cnt_d       = cnt_q;
        out_wrap_d  = 1'b0;
        out_count_d = out_count_q;
`endif

        if (found) begin
            ptr_d = pick + CW'(1);
            // A config write to the serviced channel wins; the step is dropped.
            if (!collide) begin
                x_d[pick]   = rx;
                y_d[pick]   = ry;
                out_valid_d = 1'b1;
                out_chan_d  = pick;
                out_sin_d   = rx;
                out_cos_d   = ry;
`ifdef OSC_SCHED_WRAP_CNT_EN
                if (x_q[pick][BITS-1] && !rx[BITS-1]) begin
                    cnt_d[pick] = cnt_q[pick] + 16'd1;
                    out_wrap_d  = 1'b1;
                end
                out_count_d = cnt_d[pick];
`endif
            end
        end

        if (accept) begin
            shift_d[cfg_chan] = shift_cl;
            en_d[cfg_chan]    = cfg_enable;
            // Only a fresh start reloads phase; a running channel keeps its phase.
            if (cfg_enable && !en_q[cfg_chan]) begin
                x_d[cfg_chan] = MAX;
                y_d[cfg_chan] = '0;
`ifdef OSC_SCHED_WRAP_CNT_EN
                cnt_d[cfg_chan] = '0;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                x_q[i]     <= MAX;
                y_q[i]     <= '0;
                shift_q[i] <= 4'(DEF_SHIFT);
`ifdef OSC_SCHED_WRAP_CNT_EN
                cnt_q[i]   <= '0;
`endif
            end
            en_q        <= '0;
            ptr_q       <= '0;
            cfg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_sin_q   <= '0;
            out_cos_q   <= '0;
`ifdef OSC_SCHED_WRAP_CNT_EN
            out_wrap_q  <= 1'b0;
            out_count_q <= '0;
`endif
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            shift_q     <= shift_d;
            en_q        <= en_d;
            ptr_q       <= ptr_d;
            cfg_ready_q <= cfg_ready_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_sin_q   <= out_sin_d;
            out_cos_q   <= out_cos_d;
`ifdef OSC_SCHED_WRAP_CNT_EN
            cnt_q       <= cnt_d;
            out_wrap_q  <= out_wrap_d;
            out_count_q <= out_count_d;
`endif
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_sin   = out_sin_q;
    assign out_cos   = out_cos_q;
`ifdef OSC_SCHED_WRAP_CNT_EN
    assign out_wrap  = out_wrap_q;
    assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_osc_scheduler.sv
// Self-checking bench for osc_scheduler: directed config sequences, hand-computed samples,
// and a small cycle-level reference model compared after every clock.
module tb_osc_scheduler;

    localparam int BITS = 20;
    localparam int NCH  = 4;
    localparam int MAXV = 524287;

    logic                   clk;
    logic                   reset;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [1:0]             cfg_chan;
    logic [3:0]             cfg_shift;
    logic                   cfg_enable;
    logic                   out_valid;
    logic [1:0]             out_chan;
    logic signed [BITS-1:0] out_sin;
    logic signed [BITS-1:0] out_cos;
`ifdef OSC_SCHED_WRAP_CNT_EN
    logic                   out_wrap;
    logic [15:0]            out_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x [NCH];
    int m_y [NCH];
    int m_sh [NCH];
    bit m_en [NCH];
    int m_ptr;
    bit m_vld;
    bit m_rdy;
    int m_chan;
    int m_sin;
    int m_cos;

    osc_scheduler #(
        .BITS      (BITS),
        .CHANNELS  (NCH),
        .DEF_SHIFT (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_shift  (cfg_shift),
        .cfg_enable (cfg_enable),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .out_sin    (out_sin),
        .out_cos    (out_cos)
`ifdef OSC_SCHED_WRAP_CNT_EN
        ,
        .out_wrap   (out_wrap),
        .out_count  (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs as they stand before the edge.
    task automatic model_edge();
        bit acc;
        bit fnd;
        int pc;
        int c;
        int s;
        int nx;
        int ny;
        int sh;
        int ch;
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                m_en[k] = 1'b0;
                m_sh[k] = 5;
                m_x[k]  = MAXV;
                m_y[k]  = 0;
            end
            m_ptr = 0; m_vld = 0; m_rdy = 0; m_chan = 0; m_sin = 0; m_cos = 0;
            return;
        end
        ch  = int'(cfg_chan);
        acc = cfg_valid && m_rdy;
        fnd = 1'b0;
        pc  = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (!fnd && m_en[c]) begin
                fnd = 1'b1;
                pc  = c;
            end
        end
        m_vld = 1'b0;
        if (fnd) begin
            m_ptr = (pc + 1) % NCH;
            if (!(acc && ch == pc)) begin
                s  = m_sh[pc];
                nx = m_x[pc] + (m_y[pc] >>> s) - (m_x[pc] >>> (2 * s + 1));
                ny = m_y[pc] - (m_x[pc] >>> s) - (m_y[pc] >>> (2 * s + 1));
                if (nx > MAXV)       begin nx = MAXV;  ny = 0;     end
                else if (ny > MAXV)  begin nx = 0;     ny = MAXV;  end
                else if (nx < -MAXV) begin nx = -MAXV; ny = 0;     end
                else if (ny < -MAXV) begin nx = 0;     ny = -MAXV; end
                m_x[pc] = nx;
                m_y[pc] = ny;
                m_vld   = 1'b1;
                m_chan  = pc;
                m_sin   = nx;
                m_cos   = ny;
            end
        end
        if (acc) begin
            sh = int'(cfg_shift);
            if (sh == 0) sh = 1;
            if (sh > 9) sh = 9;
            if (cfg_enable && !m_en[ch]) begin
                m_x[ch] = MAXV;
                m_y[ch] = 0;
            end
            m_en[ch] = cfg_enable;
            m_sh[ch] = sh;
        end
        m_rdy = !acc;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("m_valid", int'(out_valid), int'(m_vld));
        check("m_ready", int'(cfg_ready), int'(m_rdy));
        check("m_chan", int'(out_chan), m_chan);
        check("m_sin", int'(out_sin), m_sin);
        check("m_cos", int'(out_cos), m_cos);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int sh, input bit en);
        int n;
        n = 0;
        while (!cfg_ready && n < 10) begin
            tick();
            n++;
        end
        check("cfg_ready_wait", int'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_shift  = 4'(sh);
        cfg_enable = en;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        bit seen;
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_shift  = '0;
        cfg_enable = 1'b0;

        // Reset state and cfg_ready release
        do_reset(3);
        check("rst_valid", int'(out_valid), 0);
        check("rst_chan", int'(out_chan), 0);
        check("rst_sin", int'(out_sin), 0);
        check("rst_cos", int'(out_cos), 0);
        check("rst_ready_first", int'(cfg_ready), 0);
        tick();
        check("rst_ready_then", int'(cfg_ready), 1);

        // Single channel: first sample and repeated service
        cfg_write(0, 5, 1'b1);
        check("ch0_no_sample_yet", int'(out_valid), 0);
        tick();
        check("ch0_first_valid", int'(out_valid), 1);
        check("ch0_first_chan", int'(out_chan), 0);
        check("ch0_first_sin", int'(out_sin), 524032);
        check("ch0_first_cos", int'(out_cos), -16383);
        repeat (4) begin
            tick();
            check("ch0_repeat_chan", int'(out_chan), 0);
        end

        // All four channels: continuous round-robin
        do_reset(2);
        tick();
        for (int c = 0; c < NCH; c++) cfg_write(c, 5, 1'b1);
        repeat (8) begin
            tick();
            check("all_valid_cont", int'(out_valid), 1);
        end

        // Held cfg_valid: ready alternates, disables ch0 then ch2
        cfg_valid  = 1'b1;
        cfg_chan   = 2'd0;
        cfg_shift  = 4'd5;
        cfg_enable = 1'b0;
        check("bb_ready_0", int'(cfg_ready), 1);
        tick();
        check("bb_ready_1", int'(cfg_ready), 0);
        cfg_chan = 2'd2;
        tick();
        check("bb_ready_2", int'(cfg_ready), 1);
        tick();
        check("bb_ready_3", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        repeat (6) begin
            tick();
            check("odd_valid", int'(out_valid), 1);
            check("odd_chan", int'(out_chan) % 2, 1);
        end

        // Shift clamp low: shift 0 acts as 1, third step saturates
        do_reset(2);
        tick();
        cfg_write(0, 0, 1'b1);
        tick();
        check("s1_sin_1", int'(out_sin), 458752);
        check("s1_cos_1", int'(out_cos), -262143);
        tick();
        check("s1_sin_2", int'(out_sin), 270336);
        check("s1_cos_2", int'(out_cos), -458751);
        tick();
        check("s1_sat_sin", int'(out_sin), 0);
        check("s1_sat_cos", int'(out_cos), -524287);

        // Shift clamp high: shift 15 acts as 9
        do_reset(2);
        tick();
        cfg_write(1, 15, 1'b1);
        tick();
        check("s9_chan", int'(out_chan), 1);
        check("s9_sin", int'(out_sin), 524287);
        check("s9_cos", int'(out_cos), -1023);

        // Collision: retune ch0 in the cycle it is serviced
        do_reset(2);
        tick();
        cfg_write(0, 5, 1'b1);
        tick();
        cfg_write(0, 3, 1'b1);
        check("coll_no_valid", int'(out_valid), 0);
        tick();
        check("coll_next_valid", int'(out_valid), 1);
        check("coll_next_sin", int'(out_sin), 517890);
        check("coll_next_cos", int'(out_cos), -81759);

        // Disable ch2 mid-run, then re-enable: restarts from the reset phase
        do_reset(2);
        tick();
        for (int c = 0; c < NCH; c++) cfg_write(c, 5, 1'b1);
        repeat (4) tick();
        cfg_write(2, 5, 1'b0);
        repeat (6) begin
            tick();
            check("ch2_frozen", int'(out_chan == 2'd2), 0);
        end
        cfg_write(2, 5, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (out_valid && out_chan == 2'd2) begin
                seen = 1'b1;
                check("ch2_restart_sin", int'(out_sin), 524032);
                check("ch2_restart_cos", int'(out_cos), -16383);
            end
        end
        check("ch2_restart_seen", int'(seen), 1);

        // Reset in the middle of operation
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_sin", int'(out_sin), 0);
        check("midrst_cos", int'(out_cos), 0);
        check("midrst_ready", int'(cfg_ready), 0);
        tick();
        check("midrst_idle", int'(out_valid), 0);

`ifdef OSC_SCHED_WRAP_CNT_EN
        // Wrap detection: x crosses from negative to non-negative on ch0
        begin
            int prev_sin;
            do_reset(2);
            tick();
            cfg_write(0, 5, 1'b1);
            prev_sin = 0;
            seen = 1'b0;
            for (int k = 0; k < 600 && !seen; k++) begin
                tick();
                if (out_wrap) seen = 1'b1;
                else prev_sin = int'(out_sin);
            end
            check("wrap_seen", int'(seen), 1);
            check("wrap_count", int'(out_count), 1);
            check("wrap_prev_neg", int'(prev_sin < 0), 1);
            check("wrap_now_nonneg", int'(out_sin >= 0), 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
